// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports and the shared ALU connection.
// The slave modport is the arbiter's view. The master modport is the
// view of the clients and of the ALU.
interface alu_arbiter_if #(
   parameter int DW = 4,
   parameter int RW = 8,
   parameter int SW = 2
);
   logic          req0;
   logic          req1;
   logic [DW-1:0] a0;
   logic [DW-1:0] b0;
   logic [DW-1:0] a1;
   logic [DW-1:0] b1;
   logic [SW-1:0] s0;
   logic [SW-1:0] s1;
   logic          ack0;
   logic          ack1;
   logic [RW-1:0] y0;
   logic [RW-1:0] y1;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [SW-1:0] alu_s;
   logic [RW-1:0] alu_y;
   logic          busy;

   modport slave (
      input  req0, req1, a0, b0, a1, b1, s0, s1, alu_y,
      output ack0, ack1, y0, y1, alu_a, alu_b, alu_s, busy
   );

   modport master (
      output req0, req1, a0, b0, a1, b1, s0, s1, alu_y,
      input  ack0, ack1, y0, y1, alu_a, alu_b, alu_s, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational 4-bit ALU
// between two requesters. The granted operands and opcode are registered onto
// the ALU inputs. One cycle later the ALU result is captured into the owner's
// result register and the owner receives a one-cycle ack.
module alu_arbiter #(
   parameter int DW = 4,
   parameter int RW = 8,
   parameter int SW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_reg,  state_next;
   logic          prio_reg,   prio_next;
   logic          owner_reg,  owner_next;
   logic [DW-1:0] alu_a_reg,  alu_a_next;
   logic [DW-1:0] alu_b_reg,  alu_b_next;
   logic [SW-1:0] alu_s_reg,  alu_s_next;
   logic [RW-1:0] y0_reg,     y0_next;
   logic [RW-1:0] y1_reg,     y1_next;
   logic          ack0_reg,   ack0_next;
   logic          ack1_reg,   ack1_next;
   logic          grant;

   // State and datapath registers. An asynchronous reset aborts any operation
   // in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         prio_reg  <= 1'b0;
         owner_reg <= 1'b0;
         alu_a_reg <= '0;
         alu_b_reg <= '0;
         alu_s_reg <= '0;
         y0_reg    <= '0;
         y1_reg    <= '0;
         ack0_reg  <= 1'b0;
         ack1_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         prio_reg  <= prio_next;
         owner_reg <= owner_next;
         alu_a_reg <= alu_a_next;
         alu_b_reg <= alu_b_next;
         alu_s_reg <= alu_s_next;
         y0_reg    <= y0_next;
         y1_reg    <= y1_next;
         ack0_reg  <= ack0_next;
         ack1_reg  <= ack1_next;
      end
   end

   // Next-state logic. IDLE arbitrates and latches operands. EXEC captures
   // the settled ALU result and raises ack. RESP drops ack and moves the
   // priority pointer away from the port just served.
   always_comb begin
      state_next = state_reg;
      prio_next  = prio_reg;
      owner_next = owner_reg;
      alu_a_next = alu_a_reg;
      alu_b_next = alu_b_reg;
      alu_s_next = alu_s_reg;
      y0_next    = y0_reg;
      y1_next    = y1_reg;
      ack0_next  = 1'b0;
      ack1_next  = 1'b0;
      grant      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // A lone requester wins outright. A tie goes to prio.
               grant      = (bus.req0 && bus.req1) ? prio_reg : bus.req1;
               owner_next = grant;
               if (grant) begin
                  alu_a_next = bus.a1;
                  alu_b_next = bus.b1;
                  alu_s_next = bus.s1;
               end else begin
                  alu_a_next = bus.a0;
                  alu_b_next = bus.b0;
                  alu_s_next = bus.s0;
               end
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (owner_reg) begin
               y1_next   = bus.alu_y;
               ack1_next = 1'b1;
            end else begin
               y0_next   = bus.alu_y;
               ack0_next = 1'b1;
            end
            state_next = RESP;
         end
         RESP: begin
            prio_next  = ~owner_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.ack0  = ack0_reg;
   assign bus.ack1  = ack1_reg;
   assign bus.y0    = y0_reg;
   assign bus.y1    = y1_reg;
   assign bus.alu_a = alu_a_reg;
   assign bus.alu_b = alu_b_reg;
   assign bus.alu_s = alu_s_reg;
   assign bus.busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. The bench also models the shared ALU.
// The expected results in the vector table are hand-computed constants.
module tb_alu_arbiter;

   logic clk;
   logic rst_n;

   alu_arbiter_if #(.DW(4), .RW(8), .SW(2)) bus ();

   alu_arbiter #(.DW(4), .RW(8), .SW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: 00 buffer A, 01 binary add, 10 BCD add, 11 multiply.
   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] s);
      logic [4:0] sum;
      logic [4:0] adj;
      logic       ovf;
      logic [7:0] r;
      sum = {1'b0, a} + {1'b0, b};
      adj = sum + 5'd6;
      ovf = (a[3] == b[3]) && (sum[3] != a[3]);
      case (s)
         2'b00:   r = {4'h0, a};
         2'b01:   r = {2'b00, ovf, sum};
         2'b10:   r = (sum > 5'd9) ? {3'b000, 1'b1, adj[3:0]} : {3'b000, sum};
         default: r = {4'h0, a} * {4'h0, b};
      endcase
      return r;
   endfunction

   assign bus.alu_y = alu_f(bus.alu_a, bus.alu_b, bus.alu_s);

   int n_cmp = 0;
   int n_bad = 0;
   int exp_y [2];

   typedef struct {
      int port;
      int a;
      int b;
      int s;
      int y;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int ack_of(input int p);
      return (p != 0) ? int'(bus.ack1) : int'(bus.ack0);
   endfunction

   function automatic int y_of(input int p);
      return (p != 0) ? int'(bus.y1) : int'(bus.y0);
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ack0"},  bus.ack0,  0);
      chk({tag, "_ack1"},  bus.ack1,  0);
      chk({tag, "_y0"},    bus.y0,    0);
      chk({tag, "_y1"},    bus.y1,    0);
      chk({tag, "_alu_a"}, bus.alu_a, 0);
      chk({tag, "_alu_b"}, bus.alu_b, 0);
      chk({tag, "_alu_s"}, bus.alu_s, 0);
      chk({tag, "_busy"},  bus.busy,  0);
   endtask

   // One complete operation on a single port, starting with the FSM in IDLE.
   task automatic do_op(input int p, input int a, input int b, input int s, input int ey);
      if (p != 0) begin
         bus.a1 = 4'(a); bus.b1 = 4'(b); bus.s1 = 2'(s); bus.req1 = 1'b1;
      end else begin
         bus.a0 = 4'(a); bus.b0 = 4'(b); bus.s0 = 2'(s); bus.req0 = 1'b1;
      end
      @(posedge clk); #1;
      chk("grant_busy",  bus.busy,  1);
      chk("grant_alu_a", bus.alu_a, a);
      chk("grant_alu_b", bus.alu_b, b);
      chk("grant_alu_s", bus.alu_s, s);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(posedge clk); #1;
      chk("ack_own",   ack_of(p),     1);
      chk("ack_other", ack_of(1 - p), 0);
      chk("y_own",     y_of(p),       ey);
      chk("y_other",   y_of(1 - p),   exp_y[1 - p]);
      chk("busy_resp", bus.busy,      1);
      exp_y[p] = ey;
      @(posedge clk); #1;
      chk("ack_drop",  ack_of(p), 0);
      chk("busy_idle", bus.busy,  0);
      $display("op port=%0d a=%0h b=%0h s=%0d y=%0h (expected %0h)", p, a, b, s, y_of(p), ey);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{0,  7,  9, 1, 'h10};   // binary add, carry out
      vecs[1] = '{1,  5,  8, 2, 'h13};   // BCD add with decimal carry
      vecs[2] = '{1, 15, 15, 3, 'hE1};   // largest multiply
      vecs[3] = '{0,  3,  4, 3, 'h0C};   // multiply
      vecs[4] = '{0,  6,  5, 0, 'h06};   // buffer; y1 must keep E1
      vecs[5] = '{0,  7,  1, 1, 'h28};   // add with signed overflow
      vecs[6] = '{1,  9,  9, 2, 'h18};   // BCD 9+9
      vecs[7] = '{1, 15,  1, 1, 'h10};   // -1+1: carry, no overflow
      vecs[8] = '{0,  0,  0, 3, 'h00};   // zero multiply

      rst_n = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.a0 = 4'h0; bus.b0 = 4'h0; bus.s0 = 2'b00;
      bus.a1 = 4'h0; bus.b1 = 4'h0; bus.s1 = 2'b00;
      exp_y[0] = 0;
      exp_y[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      $display("reset state checked");

      // Simultaneous requests straight after reset: port 0 first, then
      // alternation every 3 cycles while both are held.
      bus.a0 = 4'd3; bus.b0 = 4'd4; bus.s0 = 2'b11; bus.req0 = 1'b1;
      bus.a1 = 4'd2; bus.b1 = 4'd0; bus.s1 = 2'b00; bus.req1 = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rr_ack0_k%0d", k), bus.ack0, ((k % 6) == 1) ? 1 : 0);
         chk($sformatf("rr_ack1_k%0d", k), bus.ack1, ((k % 6) == 4) ? 1 : 0);
         if (k == 0 || k == 6) chk($sformatf("rr_alu_a_k%0d", k), bus.alu_a, 3);
         if (k == 3) begin
            chk("rr_alu_a_k3", bus.alu_a, 2);
            chk("rr_alu_s_k3", bus.alu_s, 0);
         end
         if (k == 1) chk("rr_y0", bus.y0, 'h0C);
         if (k == 4) chk("rr_y1", bus.y1, 'h02);
         $display("rr cycle %0d ack0=%0d ack1=%0d alu_a=%0h", k, bus.ack0, bus.ack1, bus.alu_a);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      exp_y[0] = 'h0C;
      exp_y[1] = 'h02;
      @(posedge clk); #1;
      chk("rr_quiet_busy", bus.busy, 0);

      // Table of single-port operations.
      for (int i = 0; i < 9; i++)
         do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].y);

      // Operand change after grant is ignored.
      bus.a0 = 4'd2; bus.b0 = 4'd3; bus.s0 = 2'b01; bus.req0 = 1'b1;
      @(posedge clk); #1;
      bus.a0 = 4'd9; bus.b0 = 4'd15; bus.s0 = 2'b11; bus.req0 = 1'b0;
      @(posedge clk); #1;
      chk("chg_alu_a", bus.alu_a, 2);
      chk("chg_ack0",  bus.ack0,  1);
      chk("chg_y0",    bus.y0,    'h05);
      @(posedge clk); #1;
      chk("chg_ack_drop", bus.ack0, 0);
      $display("operand change: y0=%0h (expected 05)", bus.y0);

      // Reset during EXEC aborts the operation; held req is served afresh.
      bus.a0 = 4'd1; bus.b0 = 4'd2; bus.s0 = 2'b01; bus.req0 = 1'b1;
      @(posedge clk); #1;
      chk("mid_exec_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_async");
      @(posedge clk); #1;
      check_idle_outputs("mid_held");
      rst_n = 1'b1;
      exp_y[0] = 0;
      exp_y[1] = 0;
      do_op(0, 1, 2, 1, 'h03);
      $display("reset mid-operation recovered");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
